dbus_responder: RTL and testbench

Data-bus responder for the pipeline's memory stage: accepts one `dbus_req_t` transaction at a time from the MEM stage, services it against an internal word-addressed RAM after a programmable latency, and returns a single `addr_ok`/`data_ok` pulse carrying the read data. It is the memory-side end of the data-bus handshake. It serves as the simulation and FPGA stand-in for the cache/AXI path, so the pipeline's stall logic can be exercised at arbitrary memory latencies.

---
 rtl/dbus_responder_pkg.sv | 46 ++++
 rtl/dbus_responder_lfsr8.sv | 44 ++++
 rtl/dbus_responder.sv | 153 +++++++++++++++
 tb/tb_dbus_responder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_responder_pkg.sv
// ---------------------------------------------------------------------------
// Shared types for the data-bus responder.
//
//   package common : bus transaction records exchanged with the MEM stage
//                    (dbus_req_t / dbus_resp_t) and the 64-bit word type u64.
//   package pipes  : responder FSM state enum (dresp_state_t) and the 4-bit
//                    latency counter type (u4).
//
// No ports; imported by dbus_responder and by the testbench.
// ---------------------------------------------------------------------------

package common;

    typedef logic [63:0] u64;

    // Request from the MEM stage. size is carried for completeness only;
    // the responder selects bytes purely from strobe.
    typedef struct packed {
        logic       valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    // Response to the MEM stage. addr_ok and data_ok pulse together for
    // exactly one cycle per transaction.
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

package pipes;

    typedef logic [3:0] u4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dresp_state_t;

endpackage

// File: rtl/dbus_responder_lfsr8.sv
// ---------------------------------------------------------------------------
// lfsr8 : 8-bit Fibonacci LFSR (taps 8,6,5,4) used to randomise the
// responder latency. Only present in builds with DBUS_RESP_RANDLAT_EN
// defined; the fixed-latency build has no use for it.
//
// Parameters:
//   SEED    - nonzero reset value of the register
// Ports:
//   clk     - rising-edge clock
//   reset   - asynchronous, active-low; reloads SEED
//   advance - shift one step at the next rising edge
//   state   - current 8-bit register contents
// ---------------------------------------------------------------------------

`ifdef DBUS_RESP_RANDLAT_EN

module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [7:0] state
);

    logic [7:0] state_q;
    logic       feedback;

    // Taps 8,6,5,4 in 1-based numbering map to bits 7,5,4,3.
    assign feedback = state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= SEED;
        end else if (advance) begin
            state_q <= {state_q[6:0], feedback};
        end
    end

    assign state = state_q;

endmodule

`endif

// File: rtl/dbus_responder.sv
// ---------------------------------------------------------------------------
// dbus_responder : memory-side end of the pipeline data-bus handshake.
// Accepts one request at a time, waits a programmable latency, then returns
// a single-cycle addr_ok/data_ok pulse with the read data from an internal
// word-addressed RAM. Stores are applied byte-wise from strobe when the
// response cycle ends, so the response always carries the pre-write word.
//
// Parameters:
//   MEM_WORDS - number of 64-bit RAM words (power of two, >= 2)
//   LATENCY   - cycles from acceptance to response (1..15)
//   LFSR_SEED - nonzero seed used in random-latency builds
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous, active-low; drops any in-flight transaction
//   dreq      - request from the MEM stage (dbus_req_t)
//   dresp     - response to the MEM stage (dbus_resp_t), zero outside RESP
//
// Build option:
//   DBUS_RESP_RANDLAT_EN - when defined, each request gets a latency of
//                          (lfsr[3:0] mod LATENCY)+1 from an lfsr8 that
//                          advances once per accepted request.
// ---------------------------------------------------------------------------

module dbus_responder
    import common::*;
    import pipes::*;
#(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned LATENCY   = 2,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);

    dresp_state_t     state_q, state_d;
    u4                latCnt_q, latCnt_d;
    u4                latLoad;
    logic [IDX_W-1:0] reqIdx_q;
    logic [7:0]       reqStrobe_q;
    u64               reqData_q;
    logic             accept;
    logic             memWe;
    logic             unusedReq;

    u64 mem [MEM_WORDS];

    assign accept = (state_q == IDLE) && dreq.valid;

    // Byte offset, upper address bits and size play no part in addressing.
    assign unusedReq = ^{dreq.size, dreq.addr[63:IDX_W+3], dreq.addr[2:0]};

`ifdef DBUS_RESP_RANDLAT_EN
    logic [7:0] lfsrState;
    logic       unusedLfsr;

    lfsr8 #(
        .SEED(LFSR_SEED)
    ) uLfsr (
        .clk    (clk),
        .reset  (reset),
        .advance(accept),
        .state  (lfsrState)
    );

    // The counter holds latency-1, so the mod result loads directly.
    assign latLoad    = u4'(32'(lfsrState[3:0]) % LATENCY);
    assign unusedLfsr = ^lfsrState[7:4];
`else
    assign latLoad = u4'(LATENCY - 1);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            latCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            latCnt_q <= latCnt_d;
        end
    end

    // The request is frozen at acceptance; later changes on dreq, including
    // valid dropping, have no effect on the transaction in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reqIdx_q    <= '0;
            reqStrobe_q <= '0;
            reqData_q   <= '0;
        end else if (accept) begin
            reqIdx_q    <= dreq.addr[3 +: IDX_W];
            reqStrobe_q <= dreq.strobe;
            reqData_q   <= dreq.data;
        end
    end

    // WAIT is entered with a nonzero count and lasts that many cycles, so
    // total acceptance-to-response latency equals the loaded value plus one.
    always_comb begin
        state_d  = state_q;
        latCnt_d = latCnt_q;
        case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    latCnt_d = latLoad;
                    state_d  = (latLoad == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                latCnt_d = (latCnt_q == '0) ? '0 : latCnt_q - 4'd1;
                if (latCnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                latCnt_d = '0;
                state_d  = IDLE;
            end
            default: begin
                latCnt_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    // Response is decoded from the state alone so a reset clears it at once.
    always_comb begin
        dresp = '0;
        if (state_q == RESP) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = mem[reqIdx_q];
        end
    end

    assign memWe = (state_q == RESP) && (reqStrobe_q != 8'h00);

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < 8; i++) begin
                if (reqStrobe_q[i]) begin
                    mem[reqIdx_q][8*i +: 8] <= reqData_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dbus_responder.sv
// ---------------------------------------------------------------------------
// tb_dbus_responder : self-checking bench for dbus_responder.
// Two instances share the clock: one with LATENCY=2 and one with LATENCY=4.
// ---------------------------------------------------------------------------

module tb_dbus_responder;
    import common::*;

    typedef struct {
        string       name;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        bit          checkData;
        logic [63:0] expData;
    } vec_t;

    logic       clk;
    logic       rstn [2];
    dbus_req_t  req [2];
    dbus_resp_t resp [2];

    int         checks = 0;
    int         failures = 0;
    logic [7:0] modelLfsr [2];
    int         latParam [2];
    vec_t       vecs [10];
    int         lat;
    int         seen;
    int         l1;
    int         l2;
    int         run1 [8];
    int         run2 [8];

    dbus_responder #(
        .MEM_WORDS(4096),
        .LATENCY  (2),
        .LFSR_SEED(8'hA5)
    ) dut2 (
        .clk  (clk),
        .reset(rstn[0]),
        .dreq (req[0]),
        .dresp(resp[0])
    );

    dbus_responder #(
        .MEM_WORDS(4096),
        .LATENCY  (4),
        .LFSR_SEED(8'hA5)
    ) dut4 (
        .clk  (clk),
        .reset(rstn[1]),
        .dreq (req[1]),
        .dresp(resp[1])
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point; every check goes through here.
    task automatic checkOutput(input string name, input logic [65:0] actual, input logic [65:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference latency for the next accepted request on instance sel.
    // The reference LFSR always steps, but only drives the answer in
    // random-latency builds.
    task automatic takeLatency(input int sel, output int latOut);
        logic [7:0] s;
        s = modelLfsr[sel];
`ifdef DBUS_RESP_RANDLAT_EN
        latOut = (int'(s[3:0]) % latParam[sel]) + 1;
`else
        latOut = latParam[sel];
`endif
        modelLfsr[sel] = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endtask

    // Pulse reset on one instance and restart its reference LFSR.
    task automatic resetDut(input int sel);
        @(negedge clk);
        rstn[sel] = 1'b0;
        @(negedge clk);
        rstn[sel] = 1'b1;
        modelLfsr[sel] = 8'hA5;
    endtask

    // One full transaction: present the request for a single cycle, then
    // drop valid and scramble the other fields so only captured values can
    // produce the right answer. Waits a bounded number of cycles for the
    // response and checks latency, handshake, data and the idle cycle after.
    task automatic applyStimulus(input int sel, input string name, input logic [63:0] addr,
                                 input logic [7:0] strobe, input logic [63:0] data,
                                 input bit checkData, input logic [63:0] expData,
                                 output int seenLat);
        int expLat;
        takeLatency(sel, expLat);
        seenLat = 0;
        @(negedge clk);
        req[sel].valid  = 1'b1;
        req[sel].addr   = addr;
        req[sel].size   = 3'd3;
        req[sel].strobe = strobe;
        req[sel].data   = data;
        @(posedge clk);
        for (int k = 1; k <= 20 && seenLat == 0; k++) begin
            @(negedge clk);
            req[sel].valid  = 1'b0;
            req[sel].addr   = ~addr;
            req[sel].strobe = ~strobe;
            req[sel].data   = ~data;
            if (resp[sel].data_ok === 1'b1) begin
                seenLat = k;
                checkOutput({name, " addr_ok"}, 66'(resp[sel].addr_ok), 66'd1);
                if (checkData) begin
                    checkOutput({name, " data"}, 66'(resp[sel].data), 66'(expData));
                end
            end
        end
        checkOutput({name, " latency"}, 66'(seenLat), 66'(expLat));
        @(negedge clk);
        checkOutput({name, " idle resp"}, 66'(resp[sel]), 66'd0);
    endtask

    // Main sequence: reset values, vector table, then hand-written
    // back-to-back, reset-in-RESP and reset-in-WAIT scenarios.
    initial begin
        vecs[0] = '{"st40 full",  64'h40,                 8'hFF, 64'h1122334455667788, 1'b0, 64'h0};
        vecs[1] = '{"ld40",       64'h40,                 8'h00, 64'h0,                1'b1, 64'h1122334455667788};
        vecs[2] = '{"st40 part",  64'h40,                 8'h0F, 64'hAAAAAAAABBBBBBBB, 1'b1, 64'h1122334455667788};
        vecs[3] = '{"ld40 part",  64'h40,                 8'h00, 64'h0,                1'b1, 64'h11223344BBBBBBBB};
        vecs[4] = '{"st8000",     64'h8000,               8'hFF, 64'h00000000DEADBEEF, 1'b0, 64'h0};
        vecs[5] = '{"ld0 alias",  64'h0,                  8'h00, 64'h0,                1'b1, 64'h00000000DEADBEEF};
        vecs[6] = '{"st lane7",   64'hFFFF000000008000,   8'h80, 64'hCC00000000000000, 1'b1, 64'h00000000DEADBEEF};
        vecs[7] = '{"ld7 offset", 64'h7,                  8'h00, 64'h0,                1'b1, 64'hCC000000DEADBEEF};
        vecs[8] = '{"st10 drop",  64'h10,                 8'hFF, 64'h5,                1'b0, 64'h0};
        vecs[9] = '{"ld10",       64'h10,                 8'h00, 64'h0,                1'b1, 64'h5};

        latParam[0]  = 2;
        latParam[1]  = 4;
        modelLfsr[0] = 8'hA5;
        modelLfsr[1] = 8'hA5;
        rstn[0] = 1'b0;
        rstn[1] = 1'b0;
        req[0]  = '0;
        req[1]  = '0;

        #2;
        checkOutput("reset dresp L2", 66'(resp[0]), 66'd0);
        checkOutput("reset dresp L4", 66'(resp[1]), 66'd0);
        repeat (2) @(negedge clk);
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, vecs[i].name, vecs[i].addr, vecs[i].strobe, vecs[i].data,
                          vecs[i].checkData, vecs[i].expData, seen);
        end

        // Back-to-back: valid held high, so the request is taken again in
        // the IDLE cycle right after the first response.
        takeLatency(0, l1);
        takeLatency(0, l2);
        @(negedge clk);
        req[0].valid  = 1'b1;
        req[0].addr   = 64'h40;
        req[0].strobe = 8'h00;
        req[0].data   = 64'h0;
        @(posedge clk);
        for (int k = 1; k <= l1 + l2 + 3; k++) begin
            @(negedge clk);
            if (k == l1 + 2) req[0].valid = 1'b0;
            checkOutput($sformatf("b2b data_ok k=%0d", k), 66'(resp[0].data_ok),
                        66'((k == l1) || (k == l1 + 1 + l2)));
            if ((k == l1) || (k == l1 + 1 + l2)) begin
                checkOutput($sformatf("b2b data k=%0d", k), 66'(resp[0].data), 66'h11223344BBBBBBBB);
            end
        end

        // Reset during the RESP cycle: response must vanish without waiting
        // for a clock edge, and the pending store must never land.
        takeLatency(0, lat);
        @(negedge clk);
        req[0].valid  = 1'b1;
        req[0].addr   = 64'h40;
        req[0].strobe = 8'hFF;
        req[0].data   = 64'hFFFFFFFFFFFFFFFF;
        @(posedge clk);
        seen = 0;
        for (int k = 1; k <= 20 && seen == 0; k++) begin
            @(negedge clk);
            req[0].valid = 1'b0;
            if (resp[0].data_ok === 1'b1) seen = k;
        end
        checkOutput("rstResp reached RESP", 66'(seen), 66'(lat));
        rstn[0] = 1'b0;
        #1;
        checkOutput("rstResp async clear", 66'(resp[0]), 66'd0);
        @(negedge clk);
        rstn[0] = 1'b1;
        modelLfsr[0] = 8'hA5;
        applyStimulus(0, "rstResp no write", 64'h40, 8'h00, 64'h0, 1'b1, 64'h11223344BBBBBBBB, seen);

        // Reset two cycles into WAIT on the LATENCY=4 instance.
        applyStimulus(1, "pre20", 64'h20, 8'hFF, 64'h5555, 1'b0, 64'h0, seen);
        takeLatency(1, lat);
        @(negedge clk);
        req[1].valid  = 1'b1;
        req[1].addr   = 64'h20;
        req[1].strobe = 8'hFF;
        req[1].data   = 64'h99;
        @(posedge clk);
        @(negedge clk);
        req[1].valid = 1'b0;
        checkOutput("rstWait k1 data_ok", 66'(resp[1].data_ok), 66'd0);
        @(negedge clk);
        rstn[1] = 1'b0;
        #1;
        checkOutput("rstWait dresp", 66'(resp[1]), 66'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("rstWait held data_ok", 66'(resp[1].data_ok), 66'd0);
        end
        rstn[1] = 1'b1;
        modelLfsr[1] = 8'hA5;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("rstWait no ghost", 66'(resp[1].data_ok), 66'd0);
        end
        applyStimulus(1, "rstWait ld20", 64'h20, 8'h00, 64'h0, 1'b1, 64'h5555, seen);

`ifdef DBUS_RESP_RANDLAT_EN
        // Random latency: bounded, matches the reference LFSR, and repeats
        // identically after a reset.
        resetDut(1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, $sformatf("rand1 ld %0d", i), 64'h20, 8'h00, 64'h0, 1'b1, 64'h5555, run1[i]);
            checkOutput($sformatf("rand1 range %0d", i), 66'((run1[i] >= 1) && (run1[i] <= 4)), 66'd1);
        end
        resetDut(1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, $sformatf("rand2 ld %0d", i), 64'h20, 8'h00, 64'h0, 1'b1, 64'h5555, run2[i]);
            checkOutput($sformatf("rand repeat %0d", i), 66'(run2[i]), 66'(run1[i]));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
